// File: rtl/param_counter.sv
// Parametrised modulo counter with wrap, saturate and one-shot terminal modes.
// Latency: c_out, wrap, done and busy update one edge after inputs are sampled.
// Backpressure: none; en pauses counting, and the counter never stalls upstream.
module param_counter #(
   parameter int WIDTH   = 7,
   parameter int MOD_MAX = 127,
   parameter int INIT    = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   output logic [WIDTH-1:0] c_out,
   output logic             tc,
   output logic             wrap,
   output logic             done,
   output logic             busy
);

   localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MOD_MAX);
   localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
   localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

   localparam logic [1:0] MODE_SAT = 2'b01;
   localparam logic [1:0] MODE_ONE = 2'b10;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] c_q, c_d;
   logic             wrap_q, wrap_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] term_v;
   logic [WIDTH-1:0] start_v;
   logic [WIDTH-1:0] step_v;
   logic [WIDTH-1:0] load_clamped;
   logic             at_term;

   // Terminal and restart values follow the live direction; stepping never
   // relies on natural overflow because every wrap is decided by at_term.
   always_comb begin
      term_v       = dir ? '0 : MAX_V;
      start_v      = dir ? MAX_V : '0;
      at_term      = (c_q == term_v);
      step_v       = dir ? (c_q - ONE_V) : (c_q + ONE_V);
      load_clamped = (load_val > MAX_V) ? MAX_V : load_val;
   end

   // Next-state decode: load beats start, start beats en.
   always_comb begin
      c_d     = c_q;
      wrap_d  = 1'b0;
      done_d  = 1'b0;
      // Leaving one-shot drops back to IDLE silently.
      state_d = (mode == MODE_ONE) ? state_q : IDLE;

      if (load) begin
         c_d     = load_clamped;
         state_d = IDLE;
      end else if (start && (mode == MODE_ONE)) begin
         c_d     = start_v;
         state_d = RUN;
      end else if (en) begin
         case (mode)
            MODE_SAT: begin
               if (!at_term) begin
                  c_d = step_v;
               end
            end
            MODE_ONE: begin
               if (state_q == RUN) begin
                  // A dir flip can leave the run already sitting on T.
                  if (at_term) begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end else begin
                     c_d = step_v;
                     if (step_v == term_v) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                     end
                  end
               end
            end
            default: begin
               if (at_term) begin
                  c_d    = start_v;
                  wrap_d = 1'b1;
               end else begin
                  c_d = step_v;
               end
            end
         endcase
      end
   end

   // State register; reset drops any pending pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         c_q     <= INIT_V;
         wrap_q  <= 1'b0;
         done_q  <= 1'b0;
         state_q <= IDLE;
      end else begin
         c_q     <= c_d;
         wrap_q  <= wrap_d;
         done_q  <= done_d;
         state_q <= state_d;
      end
   end

   assign c_out = c_q;
   assign tc    = at_term;
   assign wrap  = wrap_q;
   assign done  = done_q;
   assign busy  = (state_q == RUN);

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter: default 7-bit/127 instance (a) and MOD_MAX=9 instance (b).
// Latency: expectations are queued per driven cycle and popped 1 ns after the edge.
// Backpressure: not applicable; inputs are shared by both instances.
module tb_param_counter;

   typedef struct packed {
      logic [6:0] c;
      logic       tc;
      logic       wrap;
      logic       done;
      logic       busy;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       dir = 1'b0;
   logic [1:0] mode = 2'b00;
   logic       load = 1'b0;
   logic [6:0] load_val = '0;
   logic       start = 1'b0;

   logic [6:0] c_a, c_b;
   logic       tc_a, wrap_a, done_a, busy_a;
   logic       tc_b, wrap_b, done_b, busy_b;
   exp_t       obs_a, obs_b;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   param_counter dut_a (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
      .load_val(load_val), .start(start), .c_out(c_a), .tc(tc_a),
      .wrap(wrap_a), .done(done_a), .busy(busy_a)
   );

   param_counter #(.WIDTH(7), .MOD_MAX(9), .INIT(0)) dut_b (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
      .load_val(load_val), .start(start), .c_out(c_b), .tc(tc_b),
      .wrap(wrap_b), .done(done_b), .busy(busy_b)
   );

   assign obs_a = {c_a, tc_a, wrap_a, done_a, busy_a};
   assign obs_b = {c_b, tc_b, wrap_b, done_b, busy_b};

   always #5 clk = ~clk;

   function automatic exp_t mk(input int c, input bit t, input bit w, input bit d, input bit b);
      exp_t e;
      e.c = 7'(c); e.tc = t; e.wrap = w; e.done = d; e.busy = b;
      return e;
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      rst = 1'b1;
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      cycle();
      e = exp_q.pop_front(); checks++;
      if (obs_a !== e) begin errors++;
         $display("FAIL reset_a: got c=%0d tc/wrap/done/busy=%b want c=%0d %b", obs_a.c, obs_a[3:0], e.c, e[3:0]); end
      e = exp_q.pop_front(); checks++;
      if (obs_b !== e) begin errors++;
         $display("FAIL reset_b: got c=%0d tc/wrap/done/busy=%b want c=%0d %b", obs_b.c, obs_b[3:0], e.c, e[3:0]); end
      rst = 1'b0;
   endtask

   task automatic test_wrap_full();
      exp_t e;
      mode = 2'b00; dir = 1'b0; en = 1'b1;
      for (int k = 1; k <= 130; k++) begin
         exp_q.push_back(mk(k % 128, (k % 128) == 127, k == 128, 0, 0));
         cycle();
         e = exp_q.pop_front(); checks++;
         if (obs_a !== e) begin errors++;
            $display("FAIL wrap_full k=%0d: got c=%0d tc/wrap/done/busy=%b want c=%0d %b", k, obs_a.c, obs_a[3:0], e.c, e[3:0]); end
      end
      en = 1'b0;
   endtask

   task automatic test_wrap_down();
      exp_t e;
      int seq[5] = '{2, 1, 0, 9, 8};
      mode = 2'b00; dir = 1'b1; en = 1'b0; load = 1'b1; load_val = 7'd3;
      exp_q.push_back(mk(3, 0, 0, 0, 0));
      cycle();
      e = exp_q.pop_front(); checks++;
      if (obs_b !== e) begin errors++;
         $display("FAIL down_load: got c=%0d tc/wrap/done/busy=%b want c=%0d %b", obs_b.c, obs_b[3:0], e.c, e[3:0]); end
      load = 1'b0; en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(mk(seq[i], seq[i] == 0, i == 3, 0, 0));
         cycle();
         e = exp_q.pop_front(); checks++;
         if (obs_b !== e) begin errors++;
            $display("FAIL down_step%0d: got c=%0d tc/wrap/done/busy=%b want c=%0d %b", i, obs_b.c, obs_b[3:0], e.c, e[3:0]); end
      end
      en = 1'b0; load = 1'b1; load_val = 7'd12;
      exp_q.push_back(mk(9, 0, 0, 0, 0));
      cycle();
      e = exp_q.pop_front(); checks++;
      if (obs_b !== e) begin errors++;
         $display("FAIL load_clamp: got c=%0d tc/wrap/done/busy=%b want c=%0d %b", obs_b.c, obs_b[3:0], e.c, e[3:0]); end
      load = 1'b0;
      dir = 1'b0;
      #1; checks++;
      if (tc_b !== 1'b1) begin errors++;
         $display("FAIL tc_redecode: got tc=%b want 1", tc_b); end
   endtask

   task automatic test_saturate();
      exp_t e;
      int seq[5] = '{126, 127, 127, 127, 127};
      mode = 2'b01; dir = 1'b0; en = 1'b0; load = 1'b1; load_val = 7'd125;
      exp_q.push_back(mk(125, 0, 0, 0, 0));
      cycle();
      e = exp_q.pop_front(); checks++;
      if (obs_a !== e) begin errors++;
         $display("FAIL sat_load: got c=%0d tc/wrap/done/busy=%b want c=%0d %b", obs_a.c, obs_a[3:0], e.c, e[3:0]); end
      load = 1'b0; en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(mk(seq[i], seq[i] == 127, 0, 0, 0));
         cycle();
         e = exp_q.pop_front(); checks++;
         if (obs_a !== e) begin errors++;
            $display("FAIL sat_step%0d: got c=%0d tc/wrap/done/busy=%b want c=%0d %b", i, obs_a.c, obs_a[3:0], e.c, e[3:0]); end
      end
      dir = 1'b1;
      #1; checks++;
      if (tc_a !== 1'b0) begin errors++;
         $display("FAIL sat_tc_dir: got tc=%b want 0", tc_a); end
      exp_q.push_back(mk(126, 0, 0, 0, 0));
      cycle();
      e = exp_q.pop_front(); checks++;
      if (obs_a !== e) begin errors++;
         $display("FAIL sat_reverse: got c=%0d tc/wrap/done/busy=%b want c=%0d %b", obs_a.c, obs_a[3:0], e.c, e[3:0]); end
      en = 1'b0;
   endtask

   task automatic test_oneshot();
      exp_t e;
      mode = 2'b10; dir = 1'b0; en = 1'b0; start = 1'b1;
      exp_q.push_back(mk(0, 0, 0, 0, 1));
      cycle();
      e = exp_q.pop_front(); checks++;
      if (obs_b !== e) begin errors++;
         $display("FAIL os_start: got c=%0d tc/wrap/done/busy=%b want c=%0d %b", obs_b.c, obs_b[3:0], e.c, e[3:0]); end
      start = 1'b0; en = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         if (k <= 9) exp_q.push_back(mk(k, k == 9, 0, k == 9, k != 9));
         else        exp_q.push_back(mk(9, 1, 0, 0, 0));
         cycle();
         e = exp_q.pop_front(); checks++;
         if (obs_b !== e) begin errors++;
            $display("FAIL os_run k=%0d: got c=%0d tc/wrap/done/busy=%b want c=%0d %b", k, obs_b.c, obs_b[3:0], e.c, e[3:0]); end
      end
      en = 1'b0;
   endtask

   task automatic test_pause_restart();
      exp_t e;
      int   exp_c = 0;
      int   i = 0;
      mode = 2'b10; dir = 1'b0; en = 1'b0; start = 1'b1;
      exp_q.push_back(mk(0, 0, 0, 0, 1));
      cycle();
      e = exp_q.pop_front(); checks++;
      if (obs_b !== e) begin errors++;
         $display("FAIL pause_start: got c=%0d tc/wrap/done/busy=%b want c=%0d %b", obs_b.c, obs_b[3:0], e.c, e[3:0]); end
      start = 1'b0;
      while (exp_c < 5) begin
         en = (i % 2 == 0);
         if (en) exp_c++;
         exp_q.push_back(mk(exp_c, 0, 0, 0, 1));
         cycle();
         e = exp_q.pop_front(); checks++;
         if (obs_b !== e) begin errors++;
            $display("FAIL pause_cyc%0d: got c=%0d tc/wrap/done/busy=%b want c=%0d %b", i, obs_b.c, obs_b[3:0], e.c, e[3:0]); end
         i++;
      end
      start = 1'b1; en = 1'b1;
      exp_q.push_back(mk(0, 0, 0, 0, 1));
      cycle();
      e = exp_q.pop_front(); checks++;
      if (obs_b !== e) begin errors++;
         $display("FAIL restart: got c=%0d tc/wrap/done/busy=%b want c=%0d %b", obs_b.c, obs_b[3:0], e.c, e[3:0]); end
      start = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         exp_q.push_back(mk(k, k == 9, 0, k == 9, k != 9));
         cycle();
         e = exp_q.pop_front(); checks++;
         if (obs_b !== e) begin errors++;
            $display("FAIL restart_run k=%0d: got c=%0d tc/wrap/done/busy=%b want c=%0d %b", k, obs_b.c, obs_b[3:0], e.c, e[3:0]); end
      end
      en = 1'b0;
   endtask

   task automatic test_priority_rst();
      exp_t e;
      mode = 2'b10; dir = 1'b0; en = 1'b0; start = 1'b1;
      exp_q.push_back(mk(0, 0, 0, 0, 1));
      cycle();
      e = exp_q.pop_front(); checks++;
      if (obs_b !== e) begin errors++;
         $display("FAIL prio_arm: got c=%0d tc/wrap/done/busy=%b want c=%0d %b", obs_b.c, obs_b[3:0], e.c, e[3:0]); end
      load = 1'b1; start = 1'b1; en = 1'b1; load_val = 7'd4;
      exp_q.push_back(mk(4, 0, 0, 0, 0));
      cycle();
      e = exp_q.pop_front(); checks++;
      if (obs_b !== e) begin errors++;
         $display("FAIL prio_load: got c=%0d tc/wrap/done/busy=%b want c=%0d %b", obs_b.c, obs_b[3:0], e.c, e[3:0]); end
      load = 1'b0;
      exp_q.push_back(mk(0, 0, 0, 0, 1));
      cycle();
      e = exp_q.pop_front(); checks++;
      if (obs_b !== e) begin errors++;
         $display("FAIL prio_start: got c=%0d tc/wrap/done/busy=%b want c=%0d %b", obs_b.c, obs_b[3:0], e.c, e[3:0]); end
      start = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         exp_q.push_back(mk(k, 0, 0, 0, 1));
         cycle();
         e = exp_q.pop_front(); checks++;
         if (obs_b !== e) begin errors++;
            $display("FAIL prio_run k=%0d: got c=%0d tc/wrap/done/busy=%b want c=%0d %b", k, obs_b.c, obs_b[3:0], e.c, e[3:0]); end
      end
      rst = 1'b1;
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      cycle();
      e = exp_q.pop_front(); checks++;
      if (obs_b !== e) begin errors++;
         $display("FAIL rst_mid_run: got c=%0d tc/wrap/done/busy=%b want c=%0d %b", obs_b.c, obs_b[3:0], e.c, e[3:0]); end
      rst = 1'b0; en = 1'b0; start = 1'b1;
      exp_q.push_back(mk(0, 0, 0, 0, 1));
      cycle();
      e = exp_q.pop_front(); checks++;
      if (obs_b !== e) begin errors++;
         $display("FAIL leave_arm: got c=%0d tc/wrap/done/busy=%b want c=%0d %b", obs_b.c, obs_b[3:0], e.c, e[3:0]); end
      start = 1'b0; mode = 2'b00;
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      cycle();
      e = exp_q.pop_front(); checks++;
      if (obs_b !== e) begin errors++;
         $display("FAIL leave_oneshot: got c=%0d tc/wrap/done/busy=%b want c=%0d %b", obs_b.c, obs_b[3:0], e.c, e[3:0]); end
   endtask

   initial begin
      #2;
      test_reset();
      test_wrap_full();
      test_wrap_down();
      test_saturate();
      test_oneshot();
      test_pause_restart();
      test_priority_rst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
